lsu_mem_stage: RTL and testbench
================================

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 SHALL have parameters: XLEN 32 data/address width; REG_W 5 rd index width; CSRW_W 4 csr write-enable width.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-003 SHALL have upstream ports: in_valid in 1; in_ready out 1; pc, ex_result, csrs, rs2_value in XLEN each; rd in REG_W; funct3 in 3; mem_ren, mem_wen, r_wen, jump_flag in 1 each; csr_wen in CSRW_W.
REQ-004 SHALL have downstream ports: out_valid out 1; out_ready in 1; pc_o, ex_result_o, csrs_o, mem_rdata_o out XLEN each; rd_o out REG_W; r_wen_o, mem_ren_o, jump_flag_o, misalign_o out 1 each; csr_wen_o out CSRW_W.
REQ-005 SHALL have memory bus ports: req_valid out 1; req_ready in 1; req_addr out XLEN; req_wen out 1; req_wdata out XLEN; req_wstrb out XLEN/8; rsp_valid in 1; rsp_rdata in XLEN.

Function
REQ-006 SHALL run FSM states IDLE, REQ, WAIT_RSP, HOLD.
REQ-007 IDLE: in_ready=1; on in_valid capture all inputs into registers; memory op (mem_ren|mem_wen) and aligned -> REQ; otherwise -> HOLD.
REQ-008 REQ: req_valid=1 with registered addr/wen/wdata/wstrb held stable; req_ready=1 -> WAIT_RSP.
REQ-009 WAIT_RSP: on rsp_valid latch rsp_rdata (loads) or ignore data (stores) -> HOLD; rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-010 HOLD: out_valid=1, outputs stable; out_ready=1 -> IDLE; in_ready=0 in every state except IDLE.
REQ-011 Latency: non-memory op out_valid one cycle after accept; memory op out_valid one cycle after rsp_valid; throughput at most one op per two cycles.
REQ-012 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0; misaligned op SHALL issue no bus request, go to HOLD with misalign_o=1, r_wen_o=0, mem_rdata_o=0.
REQ-013 Store strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; req_wdata = rs2 low byte/half replicated across the word.
REQ-014 Load extract: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; funct3 codes follow RV32I.
REQ-015 req_addr SHALL equal ex_result with low two bits cleared; mem_ren and mem_wen both set SHALL be treated as store.
REQ-016 Pass-through fields (pc, ex_result, csrs, rd, r_wen, csr_wen, jump_flag, mem_ren) SHALL equal captured values; mem_rdata_o=0 for non-loads.

Reset
REQ-017 Reset SHALL force IDLE, all captured registers 0, out_valid=0, req_valid=0, in_ready=1 once deasserted; all outputs 0 during reset.
REQ-018 Reset during REQ/WAIT_RSP SHALL abandon the transaction; a late rsp_valid after reset SHALL be ignored.

Structure
REQ-019 Shared package lsu_pkg SHALL hold the FSM state enum, funct3 load/store codes and XLEN default.
REQ-020 Combinational sub-module lsu_align SHALL implement strobe, write-data replication, load extraction and misalign detect.

Verification
REQ-021 LW addr 0x100, req_ready=1, rsp 1 cycle later rdata 0xDEADBEEF -> mem_rdata_o=0xDEADBEEF, out_valid 1 cycle after rsp_valid.
REQ-022 LB addr 0x103, rdata 0x80112233 -> mem_rdata_o=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF8011.
REQ-023 SH addr 0x202, rs2 0x1234ABCD -> req_addr 0x200, wstrb 4'b1100, wdata 0xABCDABCD.
REQ-024 LW addr 0x101 -> no req_valid ever, out_valid with misalign_o=1, r_wen_o=0.
REQ-025 ALU op with out_ready=0 for 3 cycles -> outputs stable, in_ready=0 until out_ready handshake, then IDLE.
REQ-026 rst asserted in WAIT_RSP, then rsp_valid -> IDLE, out_valid stays 0, next op proceeds normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory stage.
// Holds the FSM state encoding and the RV32I load/store funct3 codes.
package lsu_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2,
      HOLD     = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobes, store data replication, load extraction
// with sign/zero extension, and alignment checking. Purely combinational.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [2:0]        funct3,
   input  logic [1:0]        addr_lo,
   input  logic [XLEN-1:0]   rs2_value,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN/8-1:0] wstrb,
   output logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   load_data,
   output logic              misalign
);

   localparam int SW_W = XLEN / 8;

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted   = rdata >> {addr_lo, 3'b000};
      wstrb     = '0;
      wdata     = '0;
      load_data = '0;
      misalign  = 1'b0;

      // funct3[1:0] encodes the access size for both loads and stores
      case (funct3[1:0])
         2'b00: begin
            wstrb = SW_W'(1) << addr_lo;
            wdata = {(XLEN/8){rs2_value[7:0]}};
         end
         2'b01: begin
            misalign = addr_lo[0];
            wstrb    = SW_W'(3) << addr_lo;
            wdata    = {(XLEN/16){rs2_value[15:0]}};
         end
         default: begin
            misalign = |addr_lo;
            wstrb    = '1;
            wdata    = rs2_value;
         end
      endcase

      case (funct3)
         F3_LB:   load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_LH:   load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_LBU:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_LHU:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// Pipeline memory stage: accepts one instruction, performs at most one bus
// transaction for it, then holds the result until the downstream stage takes it.
module lsu_mem_stage
   import lsu_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_W  = 5,
   parameter int CSRW_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   // upstream
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   pc,
   input  logic [XLEN-1:0]   ex_result,
   input  logic [XLEN-1:0]   csrs,
   input  logic [XLEN-1:0]   rs2_value,
   input  logic [REG_W-1:0]  rd,
   input  logic [2:0]        funct3,
   input  logic              mem_ren,
   input  logic              mem_wen,
   input  logic              r_wen,
   input  logic              jump_flag,
   input  logic [CSRW_W-1:0] csr_wen,
   // downstream
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   pc_o,
   output logic [XLEN-1:0]   ex_result_o,
   output logic [XLEN-1:0]   csrs_o,
   output logic [XLEN-1:0]   mem_rdata_o,
   output logic [REG_W-1:0]  rd_o,
   output logic              r_wen_o,
   output logic              mem_ren_o,
   output logic              jump_flag_o,
   output logic              misalign_o,
   output logic [CSRW_W-1:0] csr_wen_o,
   // memory bus
   output logic              req_valid,
   input  logic              req_ready,
   output logic [XLEN-1:0]   req_addr,
   output logic              req_wen,
   output logic [XLEN-1:0]   req_wdata,
   output logic [XLEN/8-1:0] req_wstrb,
   input  logic              rsp_valid,
   input  logic [XLEN-1:0]   rsp_rdata,
   // debug
   output lsu_state_e        dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; a valid output and its payload stay stable until that edge.

   lsu_state_e        state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   ex_result_q, ex_result_d;
   logic [XLEN-1:0]   csrs_q, csrs_d;
   logic [REG_W-1:0]  rd_q, rd_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              r_wen_q, r_wen_d;
   logic              mem_ren_q, mem_ren_d;
   logic              jump_flag_q, jump_flag_d;
   logic [CSRW_W-1:0] csr_wen_q, csr_wen_d;
   logic              misalign_q, misalign_d;
   logic [XLEN-1:0]   mem_rdata_q, mem_rdata_d;
   logic [XLEN-1:0]   req_addr_q, req_addr_d;
   logic              req_wen_q, req_wen_d;
   logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
   logic [XLEN/8-1:0] req_wstrb_q, req_wstrb_d;

   logic [2:0]        al_funct3;
   logic [1:0]        al_addr_lo;
   logic [XLEN/8-1:0] al_wstrb;
   logic [XLEN-1:0]   al_wdata;
   logic [XLEN-1:0]   al_load;
   logic              al_misalign;
   logic              in_mem_op;

   // One aligner serves both phases: live inputs while idle, captured fields later.
   assign al_funct3  = (state_q == IDLE) ? funct3 : funct3_q;
   assign al_addr_lo = (state_q == IDLE) ? ex_result[1:0] : ex_result_q[1:0];
   assign in_mem_op  = mem_ren | mem_wen;

   lsu_align #(.XLEN(XLEN)) u_align (
      .funct3    (al_funct3),
      .addr_lo   (al_addr_lo),
      .rs2_value (rs2_value),
      .rdata     (rsp_rdata),
      .wstrb     (al_wstrb),
      .wdata     (al_wdata),
      .load_data (al_load),
      .misalign  (al_misalign)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ex_result_d = ex_result_q;
      csrs_d      = csrs_q;
      rd_d        = rd_q;
      funct3_d    = funct3_q;
      r_wen_d     = r_wen_q;
      mem_ren_d   = mem_ren_q;
      jump_flag_d = jump_flag_q;
      csr_wen_d   = csr_wen_q;
      misalign_d  = misalign_q;
      mem_rdata_d = mem_rdata_q;
      req_addr_d  = req_addr_q;
      req_wen_d   = req_wen_q;
      req_wdata_d = req_wdata_q;
      req_wstrb_d = req_wstrb_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               pc_d        = pc;
               ex_result_d = ex_result;
               csrs_d      = csrs;
               rd_d        = rd;
               funct3_d    = funct3;
               mem_ren_d   = mem_ren;
               jump_flag_d = jump_flag;
               csr_wen_d   = csr_wen;
               misalign_d  = in_mem_op & al_misalign;
               r_wen_d     = r_wen & ~(in_mem_op & al_misalign);
               mem_rdata_d = '0;
               req_addr_d  = {ex_result[XLEN-1:2], 2'b00};
               // mem_wen wins when both enables are set
               req_wen_d   = mem_wen;
               req_wdata_d = mem_wen ? al_wdata : '0;
               req_wstrb_d = mem_wen ? al_wstrb : '0;
               state_d     = (in_mem_op && !al_misalign) ? REQ : HOLD;
            end
         end
         REQ: begin
            if (req_ready) state_d = WAIT_RSP;
         end
         WAIT_RSP: begin
            if (rsp_valid) begin
               if (mem_ren_q && !req_wen_q) mem_rdata_d = al_load;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         ex_result_q <= '0;
         csrs_q      <= '0;
         rd_q        <= '0;
         funct3_q    <= '0;
         r_wen_q     <= 1'b0;
         mem_ren_q   <= 1'b0;
         jump_flag_q <= 1'b0;
         csr_wen_q   <= '0;
         misalign_q  <= 1'b0;
         mem_rdata_q <= '0;
         req_addr_q  <= '0;
         req_wen_q   <= 1'b0;
         req_wdata_q <= '0;
         req_wstrb_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ex_result_q <= ex_result_d;
         csrs_q      <= csrs_d;
         rd_q        <= rd_d;
         funct3_q    <= funct3_d;
         r_wen_q     <= r_wen_d;
         mem_ren_q   <= mem_ren_d;
         jump_flag_q <= jump_flag_d;
         csr_wen_q   <= csr_wen_d;
         misalign_q  <= misalign_d;
         mem_rdata_q <= mem_rdata_d;
         req_addr_q  <= req_addr_d;
         req_wen_q   <= req_wen_d;
         req_wdata_q <= req_wdata_d;
         req_wstrb_q <= req_wstrb_d;
      end
   end

   // in_ready is masked by rst so every output reads 0 while reset is held.
   assign in_ready    = (state_q == IDLE) & ~rst;
   assign out_valid   = (state_q == HOLD);
   assign req_valid   = (state_q == REQ);
   assign pc_o        = pc_q;
   assign ex_result_o = ex_result_q;
   assign csrs_o      = csrs_q;
   assign mem_rdata_o = mem_rdata_q;
   assign rd_o        = rd_q;
   assign r_wen_o     = r_wen_q;
   assign mem_ren_o   = mem_ren_q;
   assign jump_flag_o = jump_flag_q;
   assign misalign_o  = misalign_q;
   assign csr_wen_o   = csr_wen_q;
   assign req_addr    = req_addr_q;
   assign req_wen     = req_wen_q;
   assign req_wdata   = req_wdata_q;
   assign req_wstrb   = req_wstrb_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: expected results and bus requests are
// queued when an op is driven and compared when the stage produces them.
module tb_lsu_mem_stage;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] pc, ex_result, csrs, rs2_value;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic        mem_ren, mem_wen, r_wen, jump_flag;
   logic [3:0]  csr_wen;
   logic        out_valid, out_ready;
   logic [31:0] pc_o, ex_result_o, csrs_o, mem_rdata_o;
   logic [4:0]  rd_o;
   logic        r_wen_o, mem_ren_o, jump_flag_o, misalign_o;
   logic [3:0]  csr_wen_o;
   logic        req_valid, req_ready, req_wen, rsp_valid;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [3:0]  req_wstrb;
   lsu_state_e  dbg_state;

   typedef struct packed {
      logic [31:0] pc, ex, csrs, rdata;
      logic [4:0]  rd;
      logic        r_wen, mem_ren, jump, mis;
      logic [3:0]  csr_wen;
   } out_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   typedef struct packed {
      logic [31:0] pc, ex, csrs, rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        ren, wen, rwen, jump;
      logic [3:0]  csrw;
   } st_t;

   out_t exp_q[$];
   req_t req_q[$];
   int   errors = 0;
   int   checks = 0;

   lsu_mem_stage #(.XLEN(32), .REG_W(5), .CSRW_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .pc(pc), .ex_result(ex_result), .csrs(csrs), .rs2_value(rs2_value),
      .rd(rd), .funct3(funct3), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .r_wen(r_wen), .jump_flag(jump_flag), .csr_wen(csr_wen),
      .out_valid(out_valid), .out_ready(out_ready),
      .pc_o(pc_o), .ex_result_o(ex_result_o), .csrs_o(csrs_o),
      .mem_rdata_o(mem_rdata_o), .rd_o(rd_o), .r_wen_o(r_wen_o),
      .mem_ren_o(mem_ren_o), .jump_flag_o(jump_flag_o),
      .misalign_o(misalign_o), .csr_wen_o(csr_wen_o),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .dbg_state_o(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic out_t obs_out();
      obs_out = {pc_o, ex_result_o, csrs_o, mem_rdata_o, rd_o,
                 r_wen_o, mem_ren_o, jump_flag_o, misalign_o, csr_wen_o};
   endfunction

   function automatic st_t mk(input logic [31:0] ex, input logic [2:0] f3,
                              input logic ren, input logic wen, input logic [31:0] rs2);
      st_t s;
      s.pc   = $urandom;
      s.ex   = ex;
      s.csrs = $urandom;
      s.rs2  = rs2;
      s.rd   = 5'($urandom_range(1, 31));
      s.f3   = f3;
      s.ren  = ren;
      s.wen  = wen;
      s.rwen = ren & ~wen;
      s.jump = 1'b0;
      s.csrw = 4'($urandom_range(0, 15));
      return s;
   endfunction

   task automatic drive_in(input st_t s);
      pc = s.pc; ex_result = s.ex; csrs = s.csrs; rs2_value = s.rs2;
      rd = s.rd; funct3 = s.f3; mem_ren = s.ren; mem_wen = s.wen;
      r_wen = s.rwen; jump_flag = s.jump; csr_wen = s.csrw;
   endtask

   task automatic scramble_in();
      pc = $urandom; ex_result = $urandom; csrs = $urandom; rs2_value = $urandom;
      rd = 5'($urandom); funct3 = 3'($urandom); mem_ren = 1'($urandom);
      mem_wen = 1'($urandom); r_wen = 1'($urandom); jump_flag = 1'($urandom);
      csr_wen = 4'($urandom);
   endtask

   // driver: one full op from accept to downstream handshake
   task automatic run_op(input st_t s, input logic [31:0] rdata, input logic [31:0] exp_rdata,
                         input logic exp_mis, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                         input int rsp_gap, input int stall);
      out_t e;
      req_t r;
      logic is_mem;
      e.pc = s.pc; e.ex = s.ex; e.csrs = s.csrs; e.rdata = exp_rdata; e.rd = s.rd;
      e.r_wen = s.rwen & ~exp_mis; e.mem_ren = s.ren; e.jump = s.jump;
      e.mis = exp_mis; e.csr_wen = s.csrw;
      exp_q.push_back(e);
      is_mem = (s.ren | s.wen) & ~exp_mis;
      if (is_mem) begin
         r.addr = exp_addr; r.wen = s.wen; r.wdata = exp_wdata; r.wstrb = exp_wstrb;
         req_q.push_back(r);
      end

      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      drive_in(s);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      scramble_in();

      if (is_mem) begin
         @(negedge clk);
         r = req_q.pop_front();
         chk("req_valid", req_valid, 1);
         chk("req_addr", req_addr, r.addr);
         chk("req_wen", req_wen, r.wen);
         if (r.wen) begin
            chk("req_wdata", req_wdata, r.wdata);
            chk("req_wstrb", req_wstrb, r.wstrb);
         end
         chk("out_valid_in_req", out_valid, 0);
         chk("in_ready_busy", in_ready, 0);
         req_ready = 1'b1;
         @(posedge clk);
         #1;
         req_ready = 1'b0;
         repeat (rsp_gap) begin
            @(negedge clk);
            chk("out_valid_in_wait", out_valid, 0);
            chk("req_valid_in_wait", req_valid, 0);
         end
         @(negedge clk);
         rsp_valid = 1'b1;
         rsp_rdata = rdata;
         @(posedge clk);
         #1;
         rsp_valid = 1'b0;
         rsp_rdata = $urandom;
      end

      @(negedge clk);
      chk("out_valid", out_valid, 1);
      chk("req_valid_in_hold", req_valid, 0);
      e = exp_q.pop_front();
      chk("mem_rdata_o", mem_rdata_o, e.rdata);
      chk("misalign_o", misalign_o, e.mis);
      chk("r_wen_o", r_wen_o, e.r_wen);
      chk("passthrough", obs_out(), e);
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         chk("hold_stable", obs_out(), e);
         chk("hold_out_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("out_valid_drop", out_valid, 0);
      chk("back_to_idle", dbg_state, IDLE);
   endtask

   initial begin
      st_t s;
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; req_ready = 1'b0;
      rsp_valid = 1'b0; rsp_rdata = '0;
      pc = '0; ex_result = '0; csrs = '0; rs2_value = '0; rd = '0; funct3 = '0;
      mem_ren = 1'b0; mem_wen = 1'b0; r_wen = 1'b0; jump_flag = 1'b0; csr_wen = '0;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_valid", req_valid, 0);
      chk("rst_outputs", obs_out(), '0);
      chk("rst_req_bus", {req_addr, req_wen, req_wdata, req_wstrb}, '0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_state", dbg_state, IDLE);

      // loads
      run_op(mk(32'h100, F3_LW, 1, 0, 0), 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h100, 0, 0, 0, 0);
      run_op(mk(32'h103, F3_LB, 1, 0, 0), 32'h80112233, 32'hFFFFFF80, 0, 32'h100, 0, 0, 1, 0);
      run_op(mk(32'h103, F3_LBU, 1, 0, 0), 32'h80112233, 32'h00000080, 0, 32'h100, 0, 0, 0, 0);
      run_op(mk(32'h102, F3_LH, 1, 0, 0), 32'h80112233, 32'hFFFF8011, 0, 32'h100, 0, 0, 2, 0);
      run_op(mk(32'h102, F3_LHU, 1, 0, 0), 32'h80112233, 32'h00008011, 0, 32'h100, 0, 0, 0, 0);
      run_op(mk(32'h100, F3_LB, 1, 0, 0), 32'h80112233, 32'h00000033, 0, 32'h100, 0, 0, 0, 1);
      run_op(mk(32'h101, F3_LB, 1, 0, 0), 32'h80119233, 32'hFFFFFF92, 0, 32'h100, 0, 0, 0, 0);
      run_op(mk(32'h100, F3_LH, 1, 0, 0), 32'h80112233, 32'h00002233, 0, 32'h100, 0, 0, 0, 0);

      // stores, including both enables set
      run_op(mk(32'h202, F3_SH, 0, 1, 32'h1234ABCD), 32'hFFFFFFFF, 0, 0, 32'h200, 32'hABCDABCD, 4'b1100, 0, 0);
      run_op(mk(32'h201, F3_SB, 0, 1, 32'h1234ABCD), 32'hFFFFFFFF, 0, 0, 32'h200, 32'hCDCDCDCD, 4'b0010, 1, 0);
      run_op(mk(32'h300, F3_SW, 0, 1, 32'h1234ABCD), 32'hFFFFFFFF, 0, 0, 32'h300, 32'h1234ABCD, 4'b1111, 0, 0);
      run_op(mk(32'h403, F3_SB, 1, 1, 32'h000000EE), 32'h55555555, 0, 0, 32'h400, 32'hEEEEEEEE, 4'b1000, 0, 0);

      // misaligned: no bus request, misalign flagged
      run_op(mk(32'h101, F3_LW, 1, 0, 0), 0, 0, 1, 0, 0, 0, 0, 1);
      run_op(mk(32'h103, F3_LH, 1, 0, 0), 0, 0, 1, 0, 0, 0, 0, 0);
      run_op(mk(32'h302, F3_SW, 0, 1, 32'h11223344), 0, 0, 1, 0, 0, 0, 0, 0);

      // ALU op held by downstream for three cycles
      s = mk(32'h12345678, 3'b000, 0, 0, 32'h9);
      s.rwen = 1'b1;
      s.jump = 1'b1;
      run_op(s, 0, 0, 0, 0, 0, 0, 0, 3);

      // reset while waiting for the response, then a late response
      s = mk(32'h400, F3_LW, 1, 0, 0);
      @(negedge clk);
      drive_in(s);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      req_ready = 1'b1;
      @(posedge clk);
      #1;
      req_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_wait_state", dbg_state, WAIT_RSP);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_outputs", obs_out(), '0);
      chk("mid_rst_state", dbg_state, IDLE);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rsp_valid = 1'b1;
      rsp_rdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      rsp_valid = 1'b0;
      @(negedge clk);
      chk("late_rsp_out_valid", out_valid, 0);
      chk("late_rsp_in_ready", in_ready, 1);
      chk("late_rsp_state", dbg_state, IDLE);
      chk("late_rsp_rdata", mem_rdata_o, 0);

      run_op(mk(32'h500, F3_LW, 1, 0, 0), 32'h0BADF00D, 32'h0BADF00D, 0, 32'h500, 0, 0, 0, 0);

      // a few random non-memory ops
      for (int i = 0; i < 4; i++) begin
         s = mk($urandom, 3'($urandom_range(0, 7)), 0, 0, $urandom);
         s.rwen = 1'($urandom_range(0, 1));
         s.jump = 1'($urandom_range(0, 1));
         run_op(s, 0, 0, 0, 0, 0, 0, 0, $urandom_range(0, 2));
      end

      chk("exp_q_drained", 160'(exp_q.size()), 0);
      chk("req_q_drained", 160'(req_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
